i2c_master_ctrl: RTL
====================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 250, clk cycles per SCL quarter-period; legal range >= 2.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request; sampled only in IDLE.
REQ-005 rw  input  1  0 = write, 1 = read; captured with start.
REQ-006 addr  input  7  7-bit target address; captured with start.
REQ-007 wdata  input  8  write byte; captured with start.
REQ-008 scl  output  1  I2C clock, driven by this block.
REQ-009 sda  inout  1  I2C data, open-drain: driven 1'b0 or released to 1'bz, never driven 1.
REQ-010 busy  output  1  high from the cycle after start acceptance until return to IDLE.
REQ-011 done  output  1  one-cycle pulse on return to IDLE after any transaction.
REQ-012 ack_err  output  1  set with done when any expected ACK was NACK; held until next acceptance.
REQ-013 rdata  output  8  read byte, updated with done on successful read.

Function
REQ-014 The block SHALL perform one single-byte transaction per request: START, addr+rw, ACK, data byte, ACK/NACK, STOP.
REQ-015 A quarter-tick SHALL assert every CLK_DIV clk cycles while busy; each SCL bit period SHALL be 4 quarter phases Q0..Q3, with scl low in Q0/Q3 and high in Q1/Q2.
REQ-016 SDA SHALL change only in Q0 and SHALL be sampled at the end of Q1 (SCL high), except for START and STOP.
REQ-017 States: IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP.
REQ-018 IDLE: scl=1, sda released; start=1 captures rw/addr/wdata, clears ack_err, enters START.
REQ-019 START: sda pulled low while scl high for 2 quarters, then scl low; enters ADDR.
REQ-020 ADDR: 8 bits {addr, rw} sent MSB first, 4-bit counter 7 down to 0; enters ADDR_ACK.
REQ-021 ADDR_ACK: sda released, sampled; 0 enters DATA, 1 sets ack_err and enters STOP.
REQ-022 DATA write: wdata sent MSB first; DATA read: sda released, 8 bits shifted in MSB first.
REQ-023 DATA_ACK write: sample slave ACK, 1 sets ack_err; read: master releases sda (NACK); then STOP.
REQ-024 STOP: sda low during scl low, scl rises, sda released 2 quarters later; enters IDLE and pulses done.
REQ-025 start while busy SHALL be ignored with no side effect.
REQ-026 Clock stretching and multi-master arbitration SHALL NOT be supported; scl is never sampled.
REQ-027 Total transaction length SHALL be exactly 4*CLK_DIV*20 clk cycles from acceptance to done (2 START + 9 ADDR + 9 DATA bit-periods incl. STOP), NACK-on-address path 4*CLK_DIV*11 cycles.
REQ-028 rdata SHALL be unchanged on write or on aborted read.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, scl=1, sda released, busy=0, done=0, ack_err=0, rdata=0, counters 0, including mid-transaction; no STOP is generated.

Structure
REQ-030 Package i2c_pkg SHALL hold the state enum, phase encoding Q0..Q3 and the 7-bit address width constant.
REQ-031 Sub-module i2c_clk_gen SHALL produce the quarter-tick and phase index from CLK_DIV; FSM and shift logic stay in i2c_master_ctrl.

Verification
REQ-032 CLK_DIV=4, write addr=7'h50 wdata=8'hA5, ACKing slave model -> SDA bits 1010000_0 then 10100101, done after 320 clk, ack_err=0.
REQ-033 Read addr=7'h50, slave returns 8'h3C -> rdata=8'h3C with done, master NACK on ninth data bit, ack_err=0.
REQ-034 No slave (sda pulled up) -> ack_err=1, STOP after address, done after 176 clk, rdata unchanged.
REQ-035 start pulsed repeatedly while busy -> exactly one transaction, single done pulse.
REQ-036 rst_n asserted mid-DATA -> same cycle scl=1, sda=z, busy=0; next start runs a full clean transaction.
REQ-037 Bench checker -> SDA never changes while scl high except START/STOP edges, and sda never driven 1.

Source files
------------

// File: rtl/i2c_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_pkg                                                        |
// | Purpose  : Shared types for the single-byte I2C master: controller state |
// |            encoding, SCL quarter-phase encoding, address width and the   |
// |            per-state SCL/SDA waveform tables.                            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package i2c_pkg;

    localparam int c_addr_w = 7;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_START    = 3'd1,
        ST_ADDR     = 3'd2,
        ST_ADDR_ACK = 3'd3,
        ST_DATA     = 3'd4,
        ST_DATA_ACK = 3'd5,
        ST_STOP     = 3'd6
    } state_t;

    // Quarter phases of one SCL bit period.
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } phase_t;

    // SCL level for a given state/quarter. START keeps SCL high for the
    // first half (SDA falls there), STOP raises SCL after one low quarter.
    function automatic logic scl_level(input state_t s, input phase_t q);
        case (s)
            ST_IDLE:  return 1'b1;
            ST_START: return (q == Q0) || (q == Q1);
            ST_STOP:  return q != Q0;
            default:  return (q == Q1) || (q == Q2);
        endcase
    endfunction

    // 1 = pull SDA low, 0 = release. Data bits depend only on the current
    // shift-register MSB, which moves only at bit boundaries, so SDA can
    // only change at the start of a bit (Q0).
    function automatic logic sda_pull(input state_t s, input phase_t q,
                                      input logic rw, input logic tx_bit);
        case (s)
            ST_START: return 1'b1;
            ST_ADDR:  return ~tx_bit;
            ST_DATA:  return ~rw & ~tx_bit;
            ST_STOP:  return q != Q3;
            default:  return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_clk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_clk_gen                                                    |
// | Purpose  : Quarter-period timebase for the I2C master. While en is high |
// |            a one-cycle tick fires every CLK_DIV clocks and the 2-bit     |
// |            phase index advances Q0..Q3 on each tick.                     |
// | Ports    : clk, rst_n (async, active-low), en -> tick, phase[1:0]       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_clk_gen #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       tick,
    output logic [1:0] phase
);

    localparam int                 c_cnt_w = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_phase;

    // Counter and phase restart from zero whenever the master goes idle so
    // every transaction begins on a fresh Q0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 2'd0;
        end else if (!en) begin
            r_cnt   <= '0;
            r_phase <= 2'd0;
        end else if (r_cnt == c_last) begin
            r_cnt   <= '0;
            r_phase <= r_phase + 2'd1;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign tick  = en && (r_cnt == c_last);
    assign phase = r_phase;

endmodule
`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : i2c_master_ctrl                                                |
// | Purpose  : Single-byte I2C master: START, {addr,rw}, ACK, one data byte, |
// |            ACK/NACK, STOP. No clock stretching, no arbitration.          |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            start/rw/addr[6:0]/wdata[7:0] : request, captured in IDLE     |
// |            scl (out), sda (open-drain inout)                             |
// |            busy, done (1-cycle), ack_err, rdata[7:0]                     |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                rw,
    input  logic [c_addr_w-1:0] addr,
    input  logic [7:0]          wdata,
    output logic                scl,
    inout  wire                 sda,
    output logic                busy,
    output logic                done,
    output logic                ack_err,
    output logic [7:0]          rdata
);

    state_t     r_state;
    logic       r_rw;
    logic [7:0] r_wdata;
    logic [7:0] r_shift;
    logic [3:0] r_bit;
    logic       r_smp;
    logic       r_scl;
    logic       r_sda_low;
    logic       r_busy;
    logic       r_done;
    logic       r_ack_err;
    logic [7:0] r_rdata;

    logic       w_tick;
    logic [1:0] w_phase_idx;
    phase_t     w_phase;
    logic       w_end_bit;
    logic       w_smp_pt;

    i2c_clk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (r_busy),
        .tick  (w_tick),
        .phase (w_phase_idx)
    );

    assign w_phase   = phase_t'(w_phase_idx);
    assign w_end_bit = w_tick && (w_phase == Q3);
    // End of Q1: SCL has been high for most of a quarter, data is stable.
    assign w_smp_pt  = w_tick && (w_phase == Q1);

    // Open-drain: only ever pull low or release.
    assign sda     = r_sda_low ? 1'b0 : 1'bz;
    assign scl     = r_scl;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ack_err = r_ack_err;
    assign rdata   = r_rdata;

    // Bus pins are registered from the current state/phase, so they trail
    // the quarter boundary by one clk; both pins share that lag, keeping
    // their relative ordering intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rw      <= 1'b0;
            r_wdata   <= 8'd0;
            r_shift   <= 8'd0;
            r_bit     <= 4'd0;
            r_smp     <= 1'b0;
            r_scl     <= 1'b1;
            r_sda_low <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
            r_rdata   <= 8'd0;
        end else begin
            r_done    <= 1'b0;
            r_scl     <= scl_level(r_state, w_phase);
            r_sda_low <= sda_pull(r_state, w_phase, r_rw, r_shift[7]);
            if (w_smp_pt) begin
                r_smp <= sda;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rw      <= rw;
                        r_wdata   <= wdata;
                        r_shift   <= {addr, rw};
                        r_ack_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_end_bit) begin
                        r_bit   <= 4'd7;
                        r_state <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (w_end_bit) begin
                        r_shift <= {r_shift[6:0], r_smp};
                        if (r_bit == 4'd0) begin
                            r_state <= ST_ADDR_ACK;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (w_end_bit) begin
                        if (r_smp) begin
                            r_ack_err <= 1'b1;
                            r_state   <= ST_STOP;
                        end else begin
                            r_shift <= r_wdata;
                            r_bit   <= 4'd7;
                            r_state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // One shift serves both directions: a write moves the
                    // next bit to the MSB, a read collects the sampled bit.
                    if (w_end_bit) begin
                        r_shift <= {r_shift[6:0], r_smp};
                        if (r_bit == 4'd0) begin
                            r_state <= ST_DATA_ACK;
                        end else begin
                            r_bit <= r_bit - 1'b1;
                        end
                    end
                end
                ST_DATA_ACK: begin
                    if (w_end_bit) begin
                        if (!r_rw && r_smp) begin
                            r_ack_err <= 1'b1;
                        end
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_end_bit) begin
                        if (r_rw && !r_ack_err) begin
                            r_rdata <= r_shift;
                        end
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
